register_file_mp: RTL and testbench

- Parametrised successor of the CPU core's single-write, two-read register file.
- Generalises to NUM_READ read ports and NUM_WRITE write ports.
- Write-to-read bypass covers every write port.
- Adds a per-register busy scoreboard so the pipeline can track in-flight producers such as loads and multi-cycle ops.
- Sits in the decode/writeback boundary of the core. It replaces the two-port register file when a dual-issue or late-writeback configuration is built.

---
 rtl/register_file_mp_pkg.sv | 15 +
 rtl/register_file_mp_if.sv | 36 +++
 rtl/register_file_scoreboard.sv | 61 ++++++
 rtl/register_file_mp.sv | 103 ++++++++++
 tb/tb_register_file_mp.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared register-file constants and core-configuration defaults.
package register_file_mp_pkg;

    localparam int unsigned XLEN_DEF           = 32;
    localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_READ_DEF       = 2;
    localparam int unsigned NUM_WRITE_DEF      = 1;
    localparam int unsigned REG_ZERO           = 0;

    // Number of architectural registers for a given address width.
    function automatic int unsigned rf_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Read/write/reserve bus of the multi-port register file.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_READ       = NUM_READ_DEF,
    parameter int unsigned NUM_WRITE      = NUM_WRITE_DEF
);
    localparam int unsigned DEPTH = rf_depth(REG_ADDR_WIDTH);

    logic                                i_Enable;
    logic [NUM_READ*REG_ADDR_WIDTH-1:0]  i_Read_Addr;
    logic [NUM_READ*XLEN-1:0]            o_Read_Data;
    logic [NUM_READ-1:0]                 o_Read_Busy;
    logic [NUM_WRITE-1:0]                i_Write_Enable;
    logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] i_Write_Addr;
    logic [NUM_WRITE*XLEN-1:0]           i_Write_Data;
    logic [NUM_WRITE-1:0]                i_Write_Clear;
    logic                                i_Reserve_Enable;
    logic [REG_ADDR_WIDTH-1:0]           i_Reserve_Addr;
    logic [DEPTH-1:0]                    o_Busy_Vector;

    modport master (
        output i_Enable, i_Read_Addr, i_Write_Enable, i_Write_Addr,
               i_Write_Data, i_Write_Clear, i_Reserve_Enable, i_Reserve_Addr,
        input  o_Read_Data, o_Read_Busy, o_Busy_Vector
    );

    modport slave (
        input  i_Enable, i_Read_Addr, i_Write_Enable, i_Write_Addr,
               i_Write_Data, i_Write_Clear, i_Reserve_Enable, i_Reserve_Addr,
        output o_Read_Data, o_Read_Busy, o_Busy_Vector
    );

endinterface

// File: rtl/register_file_scoreboard.sv
// Per-register busy bits tracking outstanding producers.
// Reserve beats a same-cycle clear: the new producer supersedes the completing one.
module register_file_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_WRITE      = NUM_WRITE_DEF,
    localparam int unsigned DEPTH         = rf_depth(REG_ADDR_WIDTH)
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset_N,
    input  logic                                enable_i,
    input  logic [NUM_WRITE-1:0]                write_enable_i,
    input  logic [NUM_WRITE-1:0]                write_clear_i,
    input  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] write_addr_i,
    input  logic                                reserve_enable_i,
    input  logic [REG_ADDR_WIDTH-1:0]           reserve_addr_i,
    output logic [DEPTH-1:0]                    clear_hit_c,
    output logic [DEPTH-1:0]                    busy_vector_o
);
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // One-hot of registers completed by a clearing write this cycle.
    always_comb begin
        clear_hit_c = '0;
        if (enable_i) begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (write_enable_i[w] && write_clear_i[w]) begin
                    clear_hit_c[write_addr_i[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b1;
                end
            end
        end
        clear_hit_c[REG_ZERO] = 1'b0;
    end

    // Next busy state: reserve sets, else clear resets, else hold.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned n = 1; n < DEPTH; n++) begin
            if (enable_i && reserve_enable_i && reserve_addr_i == REG_ADDR_WIDTH'(n)) begin
                busy_d[n] = 1'b1;
            end else if (clear_hit_c[n]) begin
                busy_d[n] = 1'b0;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy bit storage.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vector_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle write bypass and busy scoreboard.
// x0 reads as zero, is never busy, and ignores writes/reserves/clears.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_READ       = NUM_READ_DEF,
    parameter int unsigned NUM_WRITE      = NUM_WRITE_DEF
) (
    input  logic               i_Clock,
    input  logic               i_Reset_N,
    register_file_mp_if.slave  bus
);
    localparam int unsigned AW    = REG_ADDR_WIDTH;
    localparam int unsigned DEPTH = rf_depth(REG_ADDR_WIDTH);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("register_file_mp: NUM_READ must be 1..4");
    end
    if (NUM_WRITE < 1 || NUM_WRITE > 2) begin : g_bad_num_write
        $error("register_file_mp: NUM_WRITE must be 1..2");
    end

    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [XLEN-1:0]  regs_d [DEPTH];
    logic [AW-1:0]    waddr  [NUM_WRITE];
    logic [XLEN-1:0]  wdata  [NUM_WRITE];
    logic [DEPTH-1:0] clear_hit_c;
    logic [DEPTH-1:0] busy_vec;

    for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr_unpack
        assign waddr[w] = bus.i_Write_Addr[w*AW +: AW];
        assign wdata[w] = bus.i_Write_Data[w*XLEN +: XLEN];
    end

    // Write ports applied in index order so the highest port wins on collision.
    always_comb begin
        regs_d = regs_q;
        if (bus.i_Enable) begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (bus.i_Write_Enable[w] && waddr[w] != ZERO_ADDR) begin
                    regs_d[waddr[w]] = wdata[w];
                end
            end
        end
    end

    // Register array storage.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            for (int unsigned n = 0; n < DEPTH; n++) begin
                regs_q[n] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_WRITE      (NUM_WRITE)
    ) u_scoreboard (
        .i_Clock          (i_Clock),
        .i_Reset_N        (i_Reset_N),
        .enable_i         (bus.i_Enable),
        .write_enable_i   (bus.i_Write_Enable),
        .write_clear_i    (bus.i_Write_Clear),
        .write_addr_i     (bus.i_Write_Addr),
        .reserve_enable_i (bus.i_Reserve_Enable),
        .reserve_addr_i   (bus.i_Reserve_Addr),
        .clear_hit_c      (clear_hit_c),
        .busy_vector_o    (busy_vec)
    );

    assign bus.o_Busy_Vector = busy_vec;

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdata_c;

        assign raddr = bus.i_Read_Addr[r*AW +: AW];

        // Stored value, overridden by any same-cycle write (highest port last).
        always_comb begin
            rdata_c = regs_q[raddr];
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (bus.i_Write_Enable[w] && waddr[w] == raddr) begin
                    rdata_c = wdata[w];
                end
            end
            if (!bus.i_Enable || raddr == ZERO_ADDR) begin
                rdata_c = '0;
            end
        end

        assign bus.o_Read_Data[r*XLEN +: XLEN] = rdata_c;
        assign bus.o_Read_Busy[r] = bus.i_Enable && (raddr != ZERO_ADDR)
                                    && busy_vec[raddr] && !clear_hit_c[raddr];
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized + directed bench for register_file_mp with a queue-based scoreboard.
module tb_register_file_mp;

    localparam int unsigned XL = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 4;
    localparam int unsigned NW = 2;

    typedef struct packed {
        logic                    en;
        logic [NR-1:0][AW-1:0]   raddr;
        logic [NW-1:0]           we;
        logic [NW-1:0][AW-1:0]   waddr;
        logic [NW-1:0][XL-1:0]   wdata;
        logic [NW-1:0]           wclr;
        logic                    res_en;
        logic [AW-1:0]           res_addr;
    } stim_t;

    typedef struct packed {
        logic [NR-1:0][XL-1:0] rdata;
        logic [NR-1:0]         rbusy;
        logic [31:0]           bvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_mp_if #(.XLEN(XL), .REG_ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();

    register_file_mp #(.XLEN(XL), .REG_ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
        .i_Clock   (clk),
        .i_Reset_N (rst_n),
        .bus       (bus)
    );

    // Architectural reference state.
    logic [XL-1:0] m_regs [32];
    bit            m_busy [32];

    exp_t exp_q [$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // What the outputs must show while stimulus s is applied, before the edge.
    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        for (int r = 0; r < NR; r++) begin
            int a;
            bit cleared;
            a = int'(s.raddr[r]);
            e.rdata[r] = m_regs[a];
            cleared = 1'b0;
            for (int w = 0; w < NW; w++) begin
                if (s.we[w] && int'(s.waddr[w]) == a) begin
                    e.rdata[r] = s.wdata[w];
                    if (s.wclr[w]) cleared = 1'b1;
                end
            end
            if (!s.en || a == 0) e.rdata[r] = '0;
            e.rbusy[r] = s.en && a != 0 && m_busy[a] && !cleared;
        end
        for (int n = 0; n < 32; n++) e.bvec[n] = m_busy[n];
        return e;
    endfunction

    // Architectural effect of the clock edge that ends stimulus s.
    function automatic void model_update(input stim_t s);
        if (!s.en) return;
        for (int w = 0; w < NW; w++) begin
            if (s.we[w] && s.waddr[w] != 0) begin
                m_regs[s.waddr[w]] = s.wdata[w];
                if (s.wclr[w]) m_busy[s.waddr[w]] = 1'b0;
            end
        end
        if (s.res_en && s.res_addr != 0) m_busy[s.res_addr] = 1'b1;
    endfunction

    task automatic drive(input stim_t s);
        bus.i_Enable         = s.en;
        bus.i_Read_Addr      = s.raddr;
        bus.i_Write_Enable   = s.we;
        bus.i_Write_Addr     = s.waddr;
        bus.i_Write_Data     = s.wdata;
        bus.i_Write_Clear    = s.wclr;
        bus.i_Reserve_Enable = s.res_en;
        bus.i_Reserve_Addr   = s.res_addr;
    endtask

    // Called shortly after a rising edge; returns shortly after the next one.
    task automatic apply(input stim_t s);
        drive(s);
        exp_q.push_back(model_expect(s));
        @(posedge clk);
        model_update(s);
        #1;
    endtask

    // Pulse reset between edges, then check outputs before any further edge.
    task automatic do_reset(input stim_t s);
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        apply(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.en = 1'b1;
        return s;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    // Monitor: outputs are combinational, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            for (int r = 0; r < NR; r++) begin
                if (bus.o_Read_Data[r*XL +: XL] !== e.rdata[r]) begin
                    miscompares++;
                    $display("FAIL rdata[%0d] vec %0d t=%0t: got %h expected %h",
                             r, vectors, $time, bus.o_Read_Data[r*XL +: XL], e.rdata[r]);
                end
                if (bus.o_Read_Busy[r] !== e.rbusy[r]) begin
                    miscompares++;
                    $display("FAIL rbusy[%0d] vec %0d t=%0t: got %b expected %b",
                             r, vectors, $time, bus.o_Read_Busy[r], e.rbusy[r]);
                end
            end
            if (bus.o_Busy_Vector !== e.bvec) begin
                miscompares++;
                $display("FAIL busy_vector vec %0d t=%0t: got %h expected %h",
                         vectors, $time, bus.o_Busy_Vector, e.bvec);
            end
        end
    end

    initial begin
        stim_t s;
        model_reset();
        drive(idle());
        repeat (2) @(posedge clk);
        #1;

        // Reset release: all ports read zero, nothing busy.
        s = idle(); s.raddr = {5'd1, 5'd31, 5'd5, 5'd0};
        do_reset(s);

        // Write to x0 is dropped, same cycle and after.
        s = idle(); s.we = 2'b01; s.waddr[0] = 5'd0; s.wdata[0] = 32'hDEADBEEF;
        apply(s);
        s = idle(); apply(s);

        // Dual write then quad read.
        s = idle(); s.we = 2'b11;
        s.waddr[0] = 5'd5; s.wdata[0] = 32'h11111111;
        s.waddr[1] = 5'd6; s.wdata[1] = 32'h22222222;
        apply(s);
        s = idle(); s.raddr = {5'd0, 5'd5, 5'd6, 5'd5}; apply(s);

        // Both ports write x7: bypass and storage take port 1.
        s = idle(); s.we = 2'b11;
        s.waddr[0] = 5'd7; s.wdata[0] = 32'hAAAA0000;
        s.waddr[1] = 5'd7; s.wdata[1] = 32'h0000BBBB;
        s.raddr = {5'd7, 5'd7, 5'd7, 5'd7};
        apply(s);
        s = idle(); s.raddr = {5'd0, 5'd7, 5'd6, 5'd7}; apply(s);

        // Scoreboard lifecycle on x10.
        s = idle(); s.res_en = 1'b1; s.res_addr = 5'd10; s.raddr[0] = 5'd10; apply(s);
        s = idle(); s.raddr[0] = 5'd10; apply(s);
        s = idle(); s.we = 2'b01; s.wclr = 2'b01; s.waddr[0] = 5'd10; s.wdata[0] = 32'h5;
        s.raddr[0] = 5'd10; apply(s);
        s = idle(); s.raddr[0] = 5'd10; apply(s);

        // Reserve and clear collide on x12: data lands, busy stays.
        s = idle(); s.res_en = 1'b1; s.res_addr = 5'd12; apply(s);
        s = idle(); s.res_en = 1'b1; s.res_addr = 5'd12;
        s.we = 2'b10; s.wclr = 2'b10; s.waddr[1] = 5'd12; s.wdata[1] = 32'h9;
        s.raddr[1] = 5'd12; apply(s);
        s = idle(); s.raddr[1] = 5'd12; apply(s);

        // Disabled: write and reserve suppressed, reads zero.
        s = idle(); s.en = 1'b0; s.we = 2'b01; s.waddr[0] = 5'd3; s.wdata[0] = 32'h7;
        s.res_en = 1'b1; s.res_addr = 5'd4; s.raddr = {5'd12, 5'd7, 5'd4, 5'd3};
        apply(s);
        s = idle(); s.raddr = {5'd12, 5'd7, 5'd4, 5'd3}; apply(s);

        // Store x3, then async reset between edges clears it without a clock.
        s = idle(); s.we = 2'b01; s.waddr[0] = 5'd3; s.wdata[0] = 32'h7; apply(s);
        s = idle(); s.raddr = {5'd12, 5'd7, 5'd4, 5'd3}; apply(s);
        do_reset(s);

        // Randomized traffic with collisions, disables and occasional reset.
        for (int i = 0; i < 600; i++) begin
            s.en       = ($urandom_range(0, 9) != 0);
            for (int r = 0; r < NR; r++) s.raddr[r] = rand_addr();
            for (int w = 0; w < NW; w++) begin
                s.waddr[w] = rand_addr();
                s.wdata[w] = $urandom();
            end
            s.we       = NW'($urandom_range(0, 3));
            s.wclr     = NW'($urandom_range(0, 3));
            s.res_en   = ($urandom_range(0, 2) == 0);
            s.res_addr = rand_addr();
            if ($urandom_range(0, 99) == 0) do_reset(s);
            else apply(s);
        end

        drive(idle());
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
